// File: rtl/mux_param_reg_if.sv
// Handshake and data bundle for mux_param_reg: N valid/ready input channels
// and one registered valid/ready output channel.
interface mux_param_reg_if #(
    parameter int unsigned LARGURA    = 4,
    parameter int unsigned N_ENTRADAS = 8,
    parameter int unsigned SEL_W      = $clog2(N_ENTRADAS)
) ();
    logic [N_ENTRADAS*LARGURA-1:0] entradas;
    logic [N_ENTRADAS-1:0]         validos;
    logic [N_ENTRADAS-1:0]         prontos;
    logic                          modo;
    logic [SEL_W-1:0]              selecao;
    logic [LARGURA-1:0]            saida;
    logic [SEL_W-1:0]              canal;
    logic                          saida_valida;
    logic                          saida_pronta;

    modport master (
        output entradas, validos, modo, selecao, saida_pronta,
        input  prontos, saida, canal, saida_valida
    );

    modport slave (
        input  entradas, validos, modo, selecao, saida_pronta,
        output prontos, saida, canal, saida_valida
    );
endinterface

// File: rtl/mux_param_reg.sv
// N-channel registered selector: fixed selection or round-robin arbitration,
// valid/ready on every input channel and on the single output.
module mux_param_reg #(
    parameter int unsigned LARGURA    = 4,
    parameter int unsigned N_ENTRADAS = 8,
    parameter int unsigned SEL_W      = $clog2(N_ENTRADAS)
) (
    input logic           clk,
    input logic           rst_n,
    mux_param_reg_if.slave bus
);
    typedef logic [SEL_W-1:0] idx_t;

    logic [LARGURA-1:0] dados [N_ENTRADAS];
    logic [LARGURA-1:0] saida_q, saida_d;
    idx_t               canal_q, canal_d;
    idx_t               ptr_q, ptr_d;
    logic               valida_q, valida_d;

    logic               livre;
    logic               tem_grant;
    logic               transfer;
    idx_t               g;
    int unsigned        rr_idx;

    for (genvar i = 0; i < N_ENTRADAS; i++) begin : g_unpack
        assign dados[i] = bus.entradas[i*LARGURA +: LARGURA];
    end

    // Candidate selection; the round-robin scan starts at ptr_q and wraps.
    always_comb begin
        tem_grant = 1'b0;
        g         = '0;
        rr_idx    = 0;
        if (bus.modo) begin
            for (int unsigned k = 0; k < N_ENTRADAS; k++) begin
                rr_idx = (32'(ptr_q) + k) % N_ENTRADAS;
                if (!tem_grant && bus.validos[idx_t'(rr_idx)]) begin
                    tem_grant = 1'b1;
                    g         = idx_t'(rr_idx);
                end
            end
        end else if ({1'b0, bus.selecao} < (SEL_W+1)'(N_ENTRADAS)) begin
            if (bus.validos[bus.selecao]) begin
                tem_grant = 1'b1;
                g         = bus.selecao;
            end
        end
    end

    assign livre       = !valida_q || bus.saida_pronta;
    assign transfer    = rst_n && livre && tem_grant;
    assign bus.prontos = transfer ? (N_ENTRADAS'(1) << g) : '0;

    always_comb begin
        saida_d  = saida_q;
        canal_d  = canal_q;
        ptr_d    = ptr_q;
        valida_d = valida_q;
        if (transfer) begin
            saida_d  = dados[g];
            canal_d  = g;
            valida_d = 1'b1;
            if (bus.modo) begin
                ptr_d = (g == idx_t'(N_ENTRADAS - 1)) ? '0 : g + idx_t'(1);
            end
        end else if (valida_q && bus.saida_pronta) begin
            valida_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida_q  <= '0;
            canal_q  <= '0;
            ptr_q    <= '0;
            valida_q <= 1'b0;
        end else begin
            saida_q  <= saida_d;
            canal_q  <= canal_d;
            ptr_q    <= ptr_d;
            valida_q <= valida_d;
        end
    end

    assign bus.saida        = saida_q;
    assign bus.canal        = canal_q;
    assign bus.saida_valida = valida_q;
endmodule

// File: tb/tb_mux_param_reg.sv
// Bench for mux_param_reg: directed vectors, a cycle-level reference model
// for the 8-channel instance, and a 6-channel instance for out-of-range select.
module tb_mux_param_reg;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_param_reg_if #(.LARGURA(4), .N_ENTRADAS(8)) bus8 ();
    mux_param_reg_if #(.LARGURA(4), .N_ENTRADAS(6)) bus6 ();

    mux_param_reg #(.LARGURA(4), .N_ENTRADAS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );
    mux_param_reg #(.LARGURA(4), .N_ENTRADAS(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .bus(bus6)
    );

    int n_cmp = 0;
    int n_err = 0;
    int delivered[$];

    int m_saida, m_canal, m_ptr;
    bit m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the rules allow this cycle; -1 means nobody.
    function automatic int grant_of(bit modo, int sel, logic [7:0] v, int ptr);
        if (!modo) return (sel < 8 && v[sel]) ? sel : -1;
        for (int k = 0; k < 8; k++)
            if (v[(ptr + k) % 8]) return (ptr + k) % 8;
        return -1;
    endfunction

    always @(negedge clk) begin
        int  g;
        bit  livre;
        logic [7:0] exp_pr;
        if (!rst_n) begin
            m_saida = 0; m_canal = 0; m_ptr = 0; m_valid = 0;
        end
        if (rst_n && bus8.saida_valida && bus8.saida_pronta)
            delivered.push_back(int'(bus8.canal));
        livre  = !m_valid || bus8.saida_pronta;
        g      = grant_of(bus8.modo, int'(bus8.selecao), bus8.validos, m_ptr);
        exp_pr = (rst_n && livre && g >= 0) ? 8'(1 << g) : 8'h00;
        check("model_saida",  32'(bus8.saida),        32'(m_saida));
        check("model_canal",  32'(bus8.canal),        32'(m_canal));
        check("model_valida", 32'(bus8.saida_valida), 32'(m_valid));
        check("model_prontos", 32'(bus8.prontos),     32'(exp_pr));
        if (rst_n) begin
            if (livre && g >= 0) begin
                m_saida = int'(bus8.entradas[g*4 +: 4]);
                m_canal = g;
                m_valid = 1;
                if (bus8.modo) m_ptr = (g + 1) % 8;
            end else if (m_valid && bus8.saida_pronta) begin
                m_valid = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt[8];
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) bus8.entradas[i*4 +: 4] = 4'(i + 3);
        bus8.validos = 8'hFF; bus8.modo = 1'b0; bus8.selecao = 3'd0; bus8.saida_pronta = 1'b1;
        bus6.entradas = 24'h543210; bus6.validos = 6'h3F; bus6.modo = 1'b0;
        bus6.selecao = 3'd7; bus6.saida_pronta = 1'b1;
        #1;
        check("reset_saida",   32'(bus8.saida), 0);
        check("reset_canal",   32'(bus8.canal), 0);
        check("reset_valida",  32'(bus8.saida_valida), 0);
        check("reset_prontos", 32'(bus8.prontos), 0);
        step(2);
        rst_n = 1'b1;

        // Fixed selection sweep
        for (int i = 0; i < 8; i++) begin
            bus8.selecao = 3'(i);
            #1;
            check("fix_prontos", 32'(bus8.prontos), 32'(1) << i);
            step(1);
            check("fix_saida",  32'(bus8.saida), 32'(i + 3));
            check("fix_canal",  32'(bus8.canal), 32'(i));
            check("fix_valida", 32'(bus8.saida_valida), 1);
        end

        // Round-robin from reset with sparse valids
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1; bus8.modo = 1'b1; bus8.validos = 8'b1010_0101;
        delivered.delete();
        step(7);
        check("rr_count", 32'(delivered.size()), 6);
        if (delivered.size() >= 6) begin
            check("rr_0", 32'(delivered[0]), 0);
            check("rr_1", 32'(delivered[1]), 2);
            check("rr_2", 32'(delivered[2]), 5);
            check("rr_3", 32'(delivered[3]), 7);
            check("rr_4", 32'(delivered[4]), 0);
            check("rr_5", 32'(delivered[5]), 2);
        end
        bus8.validos = 8'h00;
        step(2);
        delivered.delete();

        // Backpressure
        bus8.modo = 1'b0; bus8.selecao = 3'd3; bus8.validos = 8'h08;
        bus8.entradas[15:12] = 4'hA;
        step(1);
        check("bp_load_saida", 32'(bus8.saida), 32'hA);
        check("bp_load_canal", 32'(bus8.canal), 3);
        bus8.saida_pronta = 1'b0; bus8.selecao = 3'd4; bus8.validos = 8'h10;
        repeat (4) begin
            #1;
            check("bp_prontos", 32'(bus8.prontos), 0);
            step(1);
            check("bp_saida",  32'(bus8.saida), 32'hA);
            check("bp_canal",  32'(bus8.canal), 3);
            check("bp_valida", 32'(bus8.saida_valida), 1);
        end
        bus8.saida_pronta = 1'b1;
        step(1);
        check("bp_rel_saida", 32'(bus8.saida), 7);
        check("bp_rel_canal", 32'(bus8.canal), 4);
        bus8.validos = 8'h00;
        step(1);
        check("bp_items", 32'(delivered.size()), 2);
        if (delivered.size() == 2) begin
            check("bp_item0", 32'(delivered[0]), 3);
            check("bp_item1", 32'(delivered[1]), 4);
        end
        bus8.entradas[15:12] = 4'h6;

        // Fixed selection of an invalid channel; out-of-range select on N=6
        bus8.selecao = 3'd2; bus8.validos = 8'hFF;
        step(1);
        bus8.selecao = 3'd3; bus8.validos = 8'hF7;
        #1;
        check("inv_prontos", 32'(bus8.prontos), 0);
        step(1);
        check("inv_valida", 32'(bus8.saida_valida), 0);
        repeat (3) begin
            check("n6_prontos", 32'(bus6.prontos), 0);
            check("n6_valida",  32'(bus6.saida_valida), 0);
            step(1);
        end
        check("inv_valida_hold", 32'(bus8.saida_valida), 0);
        bus6.selecao = 3'd5;
        step(1);
        check("n6_sel5_canal",  32'(bus6.canal), 5);
        check("n6_sel5_saida",  32'(bus6.saida), 5);
        check("n6_sel5_valida", 32'(bus6.saida_valida), 1);

        // Asynchronous reset in the middle of a held item
        bus8.selecao = 3'd5; bus8.validos = 8'hFF; bus8.saida_pronta = 1'b0;
        step(1);
        check("ar_pre_canal", 32'(bus8.canal), 5);
        check("ar_pre_saida", 32'(bus8.saida), 8);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_saida",   32'(bus8.saida), 0);
        check("ar_canal",   32'(bus8.canal), 0);
        check("ar_valida",  32'(bus8.saida_valida), 0);
        check("ar_prontos", 32'(bus8.prontos), 0);
        check("ar_n6_valida", 32'(bus6.saida_valida), 0);
        step(1);
        rst_n = 1'b1; bus8.modo = 1'b1; bus8.saida_pronta = 1'b1;
        step(1);
        check("ar_first_grant", 32'(bus8.canal), 0);
        check("ar_first_valid", 32'(bus8.saida_valida), 1);

        // Full throughput round-robin
        delivered.delete();
        repeat (16) begin
            step(1);
            check("tp_valida", 32'(bus8.saida_valida), 1);
        end
        check("tp_count", 32'(delivered.size()), 16);
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        foreach (delivered[j]) if (delivered[j] >= 0 && delivered[j] < 8) cnt[delivered[j]]++;
        for (int i = 0; i < 8; i++) check("tp_per_channel", 32'(cnt[i]), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux_param_reg.md
Name: mux_param_reg

Overview:
Parametrised N-channel, LARGURA-bit selector with a registered output stage and valid/ready handshakes on every input channel and on the output. It is the sequential successor of the ALU's combinational 8:1 result multiplexer. It supports two modes:
- fixed selection by `selecao`;
- round-robin arbitration among the valid channels.
It sits between the ALU operation units and the result/writeback path.

Parameters:
LARGURA, 4, data width per channel and output width.
N_ENTRADAS, 8, number of input channels (2..16).
SEL_W, $clog2(N_ENTRADAS), width of selecao, canal and the internal round-robin pointer.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
entradas  input  N_ENTRADAS*LARGURA  flattened channel data; channel i is entradas[i*LARGURA +: LARGURA].
validos  input  N_ENTRADAS  per-channel valid.
prontos  output  N_ENTRADAS  per-channel ready (accept); combinational.
modo  input  1  0 = fixed selection via selecao; 1 = round-robin.
selecao  input  SEL_W  channel index used when modo=0.
saida  output  LARGURA  registered output data.
canal  output  SEL_W  index of the channel that produced saida.
saida_valida  output  1  saida/canal hold an undelivered item.
saida_pronta  input  1  downstream ready.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - saida=0, canal=0, saida_valida=0, round-robin pointer ptr=0.
  - prontos=0 while rst_n=0.
  - Reset in the middle of a transfer discards the held item; no partial state survives.
- Load enable: `livre = !saida_valida || saida_pronta`.
- Candidate channel, modo=0:
  - g = selecao, provided selecao < N_ENTRADAS and validos[selecao]=1.
  - Otherwise there is no grant; an out-of-range selecao never grants.
- Candidate channel, modo=1:
  - g = first i in the order ptr, ptr+1, ..., ptr+N_ENTRADAS-1 (mod N_ENTRADAS) with validos[i]=1.
  - If no channel is valid, there is no grant.
- prontos:
  - One-hot at bit g when livre=1 and a grant exists; otherwise all zero.
  - Never more than one bit set.
  - A channel transfers when validos[g] and prontos[g] are both 1 in the same cycle.
- On a clock edge with a transfer:
  - saida <= entradas[g]; canal <= g; saida_valida <= 1.
  - In modo=1 only, ptr <= (g+1) mod N_ENTRADAS; the wrap from N_ENTRADAS-1 goes to 0.
- On a clock edge with no transfer:
  - If saida_valida && saida_pronta, then saida_valida <= 0.
  - saida and canal keep their last values.
- Latency and throughput:
  - 1 cycle from input transfer to saida_valida=1.
  - Simultaneous output drain and new load sustains 1 item/cycle with no bubble.
- Stall (saida_valida=1, saida_pronta=0):
  - saida, canal and saida_valida are held stable; prontos=0.
- modo=0 never changes ptr.
- Switching modo or selecao affects only the next grant; the held output item is unaffected.
- Input data is sampled only on a transfer edge; entradas may change freely otherwise.

Test Plan:
1. Fixed mode, N_ENTRADAS=8, LARGURA=4, saida_pronta=1: validos=8'hFF, entradas channel i = i+3, sweep selecao 0..7 -> one cycle after each select, saida=i+3, canal=i, saida_valida=1; prontos one-hot at selecao every cycle.
2. Round-robin with validos=8'b1010_0101, saida_pronta=1 from reset -> grant sequence of canal is 0,2,5,7,0,2, one per cycle; ptr wraps from 7 to 0.
3. Backpressure: load channel 3 = 4'hA, then hold saida_pronta=0 for 4 cycles while channel 4 is valid -> saida=4'hA and canal=3 stay stable, prontos=0; on release, channel 4 is delivered the following cycle with no lost or duplicated item.
4. Fixed mode with selecao=3 and validos[3]=0 (other channels valid) -> prontos=0, saida_valida falls to 0 after drain. With N_ENTRADAS=6, selecao=7 -> no grant ever.
5. Assert rst_n=0 mid-cycle while saida_valida=1, canal=5 -> saida=0, canal=0, saida_valida=0 immediately, without waiting for a clock edge. After release in modo=1 with all channels valid, the first grant is channel 0.
6. Full throughput: modo=1, all 8 channels valid, saida_pronta=1 for 16 cycles -> 16 items delivered, each channel exactly twice, saida_valida constantly 1 after the first cycle.
